// File: rtl/alarm_pkg.sv
// Shared types and defaults for the multi-channel alarm clock.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZED = 2'd2
    } alarm_state_e;

    localparam int DAY_SEC     = 86400;
    localparam int DEF_SEC_W   = 17;
    localparam int DEF_LEN_W   = 6;
    localparam int DEF_SNOOZE  = 300;
    localparam int DEF_MAX_SNZ = 3;

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: config registers, IDLE/RINGING/SNOOZED FSM, ring/snooze/delay counters.
// Latency: next-state ring flag is combinational; the parent registers it. No backpressure.
module alarm_channel #(
    parameter int SEC_W      = 17,
    parameter int LEN_W      = 6,
    parameter int DAY_SEC    = 86400,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sec_tick_i,
    input  logic [SEC_W-1:0] cur_sec_i,
    input  logic             cfg_we_i,
    input  logic             cfg_en_i,
    input  logic [SEC_W-1:0] cfg_tar_i,
    input  logic [LEN_W-1:0] cfg_len_i,
    input  logic             off_i,
    input  logic             snooze_i,
    output logic             ring_nxt_o
);
    import alarm_pkg::*;

    localparam int SNZ_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
    localparam int DLY_W = (SNOOZE_SEC > 0) ? $clog2(SNOOZE_SEC + 1) : 1;
    localparam logic [SEC_W-1:0] TAR_MAX  = SEC_W'(DAY_SEC - 1);
    localparam logic [SNZ_W-1:0] SNZ_MAX  = SNZ_W'(MAX_SNOOZE);
    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(SNOOZE_SEC);

    alarm_state_e     state_q, state_d;
    logic             en_q, en_d;
    logic [SEC_W-1:0] tar_q, tar_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [SNZ_W-1:0] snz_q, snz_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic             hit;

    assign hit = sec_tick_i && en_q && (cur_sec_i == tar_q) && (tar_q <= TAR_MAX);

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        tar_d   = tar_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        snz_d   = snz_q;
        dly_d   = dly_q;
        if (cfg_we_i) begin
            en_d    = cfg_en_i;
            tar_d   = cfg_tar_i;
            len_d   = cfg_len_i;
            state_d = ST_IDLE;
            cnt_d   = '0;
            snz_d   = '0;
            dly_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hit) begin
                        state_d = ST_RINGING;
                        cnt_d   = '0;
                        snz_d   = '0;
                    end
                end
                ST_RINGING: begin
                    // Snooze with the budget used up is treated exactly like a dismiss.
                    if (off_i || (snooze_i && snz_q >= SNZ_MAX)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (snooze_i) begin
                        state_d = ST_SNOOZED;
                        dly_d   = DLY_LOAD;
                        snz_d   = snz_q + 1'b1;
                    end else if (sec_tick_i) begin
                        if (cnt_q == len_q) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_SNOOZED: begin
                    if (off_i) begin
                        state_d = ST_IDLE;
                        dly_d   = '0;
                    end else if (sec_tick_i) begin
                        if (dly_q <= DLY_W'(1)) begin
                            state_d = ST_RINGING;
                            cnt_d   = '0;
                            dly_d   = '0;
                        end else begin
                            dly_d = dly_q - 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            tar_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            snz_q   <= '0;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            tar_q   <= tar_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            snz_q   <= snz_d;
            dly_q   <= dly_d;
        end
    end

    assign ring_nxt_o = (state_d == ST_RINGING);

endmodule

// File: rtl/multi_alarm.sv
// N_ALARM independent alarm channels with config decode, ring OR and lowest-index encoder.
// Latency: all outputs registered, one clk after the causing event. No backpressure.
module multi_alarm #(
    parameter int N_ALARM    = 4,
    parameter int SEC_W      = alarm_pkg::DEF_SEC_W,
    parameter int LEN_W      = alarm_pkg::DEF_LEN_W,
    parameter int DAY_SEC    = alarm_pkg::DAY_SEC,
    parameter int SNOOZE_SEC = alarm_pkg::DEF_SNOOZE,
    parameter int MAX_SNOOZE = alarm_pkg::DEF_MAX_SNZ,
    localparam int IDX_W     = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sec_tick,
    input  logic [SEC_W-1:0]   cur_sec,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic               cfg_en,
    input  logic [SEC_W-1:0]   cfg_tar,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               off,
    input  logic               snooze,
    output logic [N_ALARM-1:0] ring_vec,
    output logic               alarming,
    output logic [IDX_W-1:0]   ring_idx
);

    logic [N_ALARM-1:0] ring_nxt;
    logic [N_ALARM-1:0] ring_vec_q;
    logic               alarming_q, alarming_d;
    logic [IDX_W-1:0]   ring_idx_q, ring_idx_d;

    for (genvar g = 0; g < N_ALARM; g++) begin : g_ch
        alarm_channel #(
            .SEC_W      (SEC_W),
            .LEN_W      (LEN_W),
            .DAY_SEC    (DAY_SEC),
            .SNOOZE_SEC (SNOOZE_SEC),
            .MAX_SNOOZE (MAX_SNOOZE)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .sec_tick_i (sec_tick),
            .cur_sec_i  (cur_sec),
            .cfg_we_i   (cfg_we && (cfg_idx == IDX_W'(g))),
            .cfg_en_i   (cfg_en),
            .cfg_tar_i  (cfg_tar),
            .cfg_len_i  (cfg_len),
            .off_i      (off),
            .snooze_i   (snooze),
            .ring_nxt_o (ring_nxt[g])
        );
    end

    // Encoders work on next-state ring flags so the registered outputs stay aligned with ring_vec.
    always_comb begin
        alarming_d = |ring_nxt;
        ring_idx_d = '0;
        for (int i = N_ALARM - 1; i >= 0; i--) begin
            if (ring_nxt[i]) ring_idx_d = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ring_vec_q <= '0;
            alarming_q <= 1'b0;
            ring_idx_q <= '0;
        end else begin
            ring_vec_q <= ring_nxt;
            alarming_q <= alarming_d;
            ring_idx_q <= ring_idx_d;
        end
    end

    assign ring_vec = ring_vec_q;
    assign alarming = alarming_q;
    assign ring_idx = ring_idx_q;

endmodule

// File: doc/multi_alarm.md
MULTI_ALARM -- requirements
Module: multi_alarm

Interface
REQ-001 Parameter N_ALARM, default 4: number of independent alarm channels, range 1..8.
REQ-002 Parameter SEC_W, default 17: width of second-of-day values.
REQ-003 Parameter LEN_W, default 6: width of ring length in seconds.
REQ-004 Parameter DAY_SEC, default 86400: seconds per day; wrap modulus.
REQ-005 Parameter SNOOZE_SEC, default 300: snooze delay in seconds.
REQ-006 Parameter MAX_SNOOZE, default 3: snoozes allowed per trigger.
REQ-007 One clock and one reset: reset is asynchronous and active-low.
REQ-008 clk  in  1  system clock; all state changes on its rising edge.
REQ-009 rst_n  in  1  asynchronous active-low reset.
REQ-010 sec_tick  in  1  one-cycle pulse once per second, synchronous to clk.
REQ-011 cur_sec  in  SEC_W  current second of day, 0..DAY_SEC-1; sampled only on sec_tick cycles.
REQ-012 cfg_we  in  1  configuration write strobe, one cycle.
REQ-013 cfg_idx  in  clog2(N_ALARM)  channel addressed by cfg_we.
REQ-014 cfg_en / cfg_tar / cfg_len  in  1 / SEC_W / LEN_W  enable, target second, ring length written on cfg_we.
REQ-015 off  in  1  dismiss pulse, one cycle; acts on every RINGING or SNOOZED channel.
REQ-016 snooze  in  1  snooze pulse, one cycle; acts on every RINGING channel.
REQ-017 ring_vec  out  N_ALARM  bit i high while channel i is RINGING.
REQ-018 alarming  out  1  OR of ring_vec.
REQ-019 ring_idx  out  clog2(N_ALARM)  lowest index set in ring_vec; 0 when alarming is low.

Function
REQ-020 Each channel SHALL run a FSM with states IDLE, RINGING, SNOOZED; all outputs registered, changing one clk after the causing event.
REQ-021 IDLE->RINGING on a sec_tick cycle with en=1 and cur_sec==tar; ring counter cleared to 0, snooze count cleared to 0.
REQ-022 RINGING: on each sec_tick, if counter==len go to IDLE, else increment; ring covers seconds tar..tar+len inclusive (len+1 ticks), len=0 rings exactly one second.
REQ-023 Ring window crossing midnight SHALL continue unbroken (e.g. tar=86398, len=5 rings through cur_sec 86398..3); counter-based, no comparison against tar+len.
REQ-024 RINGING + snooze with snooze count < MAX_SNOOZE -> SNOOZED, delay counter loaded with SNOOZE_SEC, snooze count incremented.
REQ-025 RINGING + snooze with snooze count == MAX_SNOOZE SHALL behave as off.
REQ-026 SNOOZED: delay counter decrements on each sec_tick; on the tick where it reaches 0 -> RINGING with ring counter 0.
REQ-027 off in RINGING or SNOOZED -> IDLE; off in IDLE has no effect.
REQ-028 Priority in one cycle: cfg write to that channel > off > snooze > sec_tick.
REQ-029 cfg_we SHALL write en/tar/len of channel cfg_idx and force it to IDLE with counters cleared; other channels unaffected.
REQ-030 en=0 SHALL hold the channel in IDLE; cfg_tar >= DAY_SEC never triggers.
REQ-031 Several channels may ring simultaneously; ring_idx reports the lowest index.

Reset
REQ-032 On rst_n low: all channels IDLE, en=0, tar=0, len=0, all counters 0, ring_vec=0, alarming=0, ring_idx=0, immediately and asynchronously.
REQ-033 Reset asserted mid-ring SHALL silence all outputs at once; after release no channel rings until reconfigured.

Structure
REQ-034 Shared package alarm_pkg SHALL hold the channel state enum, DAY_SEC and default widths.
REQ-035 One sub-module alarm_channel (FSM, config registers, counters) SHALL be instantiated N_ALARM times; multi_alarm holds cfg decode and output OR/priority encoder.

Verification
REQ-036 Ch0 en, tar=100, len=3; ticks cur_sec 99..105 -> ring_vec[0] high for cur_sec 100..103 only, alarming mirrors it.
REQ-037 Ch1 tar=86398, len=5; ticks through wrap 86397..4 -> ring high for 86398,86399,0,1,2,3, low at 4.
REQ-038 Ch0 ringing at tar=50, snooze at 51 -> low; high again after 300 ticks; 4th snooze acts as off -> IDLE, no further ring.
REQ-039 Ch0 and ch2 both tar=200 -> ring_vec=0101, ring_idx=0; off -> ring_vec=0000 next cycle; off with simultaneous snooze -> IDLE.
REQ-040 Ch3 ringing, rst_n pulled low between ticks -> outputs 0 same cycle; after release, tar match ignored (en=0).
REQ-041 cfg_we to ch1 while ch1 ringing and ch0 ringing -> ch1 IDLE next cycle, ch0 still ringing.
